mac_operand_feeder: RTL

Operand sequencer that drives the multiply-accumulate datapath. It holds up to `DEPTH` input/weight byte pairs, loaded through a write port. On `start` it streams the first `no_of_inputs` pairs, in address order, to the MAC engine over a valid/ready handshake. It flags the final pair and reports run completion. It replaces file-based operand loading with a synthesizable source for the MAC's multiplier inputs.

---
 rtl/mac_operand_feeder_if.sv | 27 ++
 rtl/mac_operand_feeder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder_if.sv
// Operand stream between the feeder and the MAC engine: one input/weight
// pair per valid/ready handshake, with a marker on the final pair of a run.
interface mac_operand_feeder_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] out_x;
    logic [DATA_W-1:0] out_w;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;

    modport master (
        output out_x,
        output out_w,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_x,
        input  out_w,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/mac_operand_feeder.sv
// Operand sequencer for the MAC datapath. Stores DEPTH input/weight pairs
// and, on start, streams the first N of them in address order, one pair
// per two cycles at best (FETCH then PRESENT). Every output is a register.
module mac_operand_feeder #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 400,
    parameter int CNT_W  = 9
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [CNT_W-1:0]     wr_addr,
    input  logic [DATA_W-1:0]    wr_x,
    input  logic [DATA_W-1:0]    wr_w,
    input  logic                 start,
    input  logic [CNT_W-1:0]     no_of_inputs,
    mac_operand_feeder_if.master bus,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] FETCH   = 2'd1;
    localparam logic [1:0] PRESENT = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_x [DEPTH];
    logic [DATA_W-1:0] mem_w [DEPTH];

    logic [1:0]        state;
    logic [CNT_W-1:0]  idx;
    logic [CNT_W-1:0]  n_lat;
    logic [CNT_W-1:0]  n_start;
    logic              at_last;
    logic [DATA_W-1:0] x_q;
    logic [DATA_W-1:0] w_q;
    logic              valid_q;
    logic              last_q;

    // Run length clamp and final-index detect for the current run.
    // NOTE: every signal written here gets a value on every path, otherwise a latch is inferred.
    always_comb begin
        n_start = no_of_inputs;
        if (no_of_inputs > DEPTH_C) begin
            n_start = DEPTH_C;
        end
        at_last = (idx == n_lat - CNT_W'(1));
    end

    // Operand storage write port; out-of-range addresses are dropped.
    // NOTE: storage has no reset so it maps onto RAM and survives a reset; control state is reset separately.
    always_ff @(posedge clk) begin
        if (wr_en && (wr_addr < DEPTH_C)) begin
            mem_x[wr_addr] <= wr_x;
            mem_w[wr_addr] <= wr_w;
        end
    end

    // Run sequencer: start handling, synchronous fetch, handshake and completion.
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            n_lat   <= '0;
            x_q     <= '0;
            w_q     <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        n_lat <= n_start;
                        idx   <= '0;
                        if (n_start != '0) begin
                            state <= FETCH;
                            busy  <= 1'b1;
                            done  <= 1'b0;
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    // Read-before-write: a same-cycle write lands after this read.
                    x_q     <= mem_x[idx];
                    w_q     <= mem_w[idx];
                    valid_q <= 1'b1;
                    last_q  <= at_last;
                    state   <= PRESENT;
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        if (at_last) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + CNT_W'(1);
                            state <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_x     = x_q;
    assign bus.out_w     = w_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;

endmodule
